// File: rtl/rotate_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : rotate_seq_if
// Description : Command, rotator and result-stream signals of rotate_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface rotate_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_amt;
    logic [1:0] cmd_mode;
    logic [2:0] cmd_count;

    logic [7:0] rot_in;
    logic [2:0] rot_shift;
    logic [7:0] rot_out;

    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_shift;
    logic       out_last;
    logic       busy;

    modport slave (
        input  cmd_valid, cmd_data, cmd_amt, cmd_mode, cmd_count,
        input  rot_out, out_ready,
        output cmd_ready, rot_in, rot_shift,
        output out_valid, out_data, out_shift, out_last, busy
    );

    modport master (
        output cmd_valid, cmd_data, cmd_amt, cmd_mode, cmd_count,
        output rot_out, out_ready,
        input  cmd_ready, rot_in, rot_shift,
        input  out_valid, out_data, out_shift, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/rotate_seq.sv
`default_nettype none
// ============================================================================
// Module      : rotate_seq
// Description : Sequences SINGLE/SWEEP/ACCUM rotate commands through an
//               external 8-bit rotator and streams the results.
// Revision    : 1.0 - initial release
// ============================================================================
module rotate_seq (
    input wire          clk,
    input wire          reset,
    rotate_seq_if.slave sif
);

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_RUN     = 1'b1;
    localparam logic [1:0] c_MODE_SWEEP = 2'b01;
    localparam logic [1:0] c_MODE_ACCUM = 2'b10;

    logic [0:0] r_state;
    logic [0:0] w_state_next;

    logic       r_accum;
    logic [2:0] r_amt;
    logic [2:0] r_k;
    logic [2:0] r_last_k;
    logic [2:0] r_eff;
    logic [7:0] r_rot_in;
    logic [2:0] r_rot_shift;
    logic [7:0] r_out_data;
    logic [2:0] r_out_shift;
    logic       r_out_valid;
    logic       r_out_last;

    logic       w_cmd_ready;
    logic       w_busy;
    logic       w_accept;
    logic       w_issue;
    logic       w_final;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_issue && w_final) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_cmd_ready = 1'b0;
        w_busy      = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            c_ST_IDLE: w_cmd_ready = 1'b1;
            c_ST_RUN: begin
                w_busy  = 1'b1;
                // A beat may go out whenever the output register is free.
                w_issue = ~r_out_valid | sif.out_ready;
            end
            default: ;
        endcase
    end

    assign w_accept = sif.cmd_valid & w_cmd_ready;
    // k is 3 bits; the final beat is detected by compare, so a total of 8 never overflows.
    assign w_final  = (r_k == r_last_k);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_accum     <= 1'b0;
            r_amt       <= 3'd0;
            r_k         <= 3'd0;
            r_last_k    <= 3'd0;
            r_eff       <= 3'd0;
            r_rot_in    <= 8'h00;
            r_rot_shift <= 3'd0;
            r_out_data  <= 8'h00;
            r_out_shift <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_accum     <= (sif.cmd_mode == c_MODE_ACCUM);
                r_amt       <= sif.cmd_amt;
                r_k         <= 3'd0;
                r_rot_in    <= sif.cmd_data;
                r_rot_shift <= sif.cmd_amt;
                r_eff       <= sif.cmd_amt;
                case (sif.cmd_mode)
                    c_MODE_SWEEP: r_last_k <= 3'd7;
                    c_MODE_ACCUM: r_last_k <= sif.cmd_count;
                    default:      r_last_k <= 3'd0;
                endcase
            end

            if (w_issue) begin
                r_out_data  <= sif.rot_out;
                r_out_shift <= r_eff;
                r_out_valid <= 1'b1;
                r_out_last  <= w_final;
                r_k         <= r_k + 3'd1;
                // r_eff tracks the total rotation the rotator is currently applying to cmd_data.
                if (r_accum) begin
                    r_rot_in <= sif.rot_out;
                    r_eff    <= r_eff + r_amt;
                end else begin
                    r_rot_shift <= r_rot_shift + 3'd1;
                    r_eff       <= r_eff + 3'd1;
                end
            end else if (r_out_valid && sif.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign sif.cmd_ready = w_cmd_ready;
    assign sif.busy      = w_busy;
    assign sif.rot_in    = r_rot_in;
    assign sif.rot_shift = r_rot_shift;
    assign sif.out_valid = r_out_valid;
    assign sif.out_data  = r_out_data;
    assign sif.out_shift = r_out_shift;
    assign sif.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_rotate_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_rotate_seq
// Description : Self-checking bench for rotate_seq with a closed-form model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_seq;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    rotate_seq_if bus ();

    rotate_seq dut (
        .clk   (clk),
        .reset (reset),
        .sif   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] b, input logic [2:0] s);
        logic [15:0] t;
        t = {b, b} << s;
        return t[15:8];
    endfunction

    // Downstream combinational rotator
    always_comb bus.rot_out = rotl(bus.rot_in, bus.rot_shift);

    // Issues one command from IDLE and scoreboards every beat against the
    // closed-form expectation. rmode: 0 ready high (with optional stall), 1 random.
    task automatic do_cmd(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                          input logic [2:0] c, input int rmode, input int stall_after,
                          input int stall_len, output int cycles);
        logic [7:0] qd[$];
        logic [2:0] qs[$];
        logic       ql[$];
        logic [2:0] sh;
        int total, consumed, stall_ctr;
        total = (m == 2'b01) ? 8 : (m == 2'b10) ? int'(c) + 1 : 1;
        for (int k = 0; k < total; k++) begin
            sh = (m == 2'b10) ? 3'((int'(a) * (k + 1)) % 8) : 3'((int'(a) + k) % 8);
            qd.push_back(rotl(d, sh));
            qs.push_back(sh);
            ql.push_back(k == total - 1);
        end
        bus.cmd_data  = d;
        bus.cmd_amt   = a;
        bus.cmd_mode  = m;
        bus.cmd_count = c;
        bus.cmd_valid = 1'b1;
        tests++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL cmd_ready_idle got %b expected 1", bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'($urandom);
        bus.cmd_amt   = 3'($urandom);
        bus.cmd_mode  = 2'($urandom);
        bus.cmd_count = 3'($urandom);
        cycles    = 0;
        consumed  = 0;
        stall_ctr = 0;
        while (qd.size() > 0 && cycles < 300) begin
            if (rmode == 1) begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end else if (consumed == stall_after && stall_ctr < stall_len) begin
                bus.out_ready = 1'b0;
                stall_ctr++;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid === 1'b1) begin
                tests++;
                if (bus.out_data !== qd[0] || bus.out_shift !== qs[0] || bus.out_last !== ql[0]) begin
                    fails++;
                    $display("FAIL beat%0d got data=%h shift=%0d last=%b expected data=%h shift=%0d last=%b",
                             consumed, bus.out_data, bus.out_shift, bus.out_last, qd[0], qs[0], ql[0]);
                end
                if (bus.out_ready) begin
                    void'(qd.pop_front());
                    void'(qs.pop_front());
                    void'(ql.pop_front());
                    consumed++;
                end
            end
            if (qd.size() > 0) begin
                @(negedge clk);
                cycles++;
            end
        end
        if (qd.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout got %0d beats expected %0d", consumed, total);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL drained got out_valid=%b busy=%b expected 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 8'h00 ||
            bus.out_shift !== 3'd0 || bus.out_last !== 1'b0 || bus.rot_in !== 8'h00 ||
            bus.rot_shift !== 3'd0) begin
            fails++;
            $display("FAIL reset_values got v=%b busy=%b d=%h sh=%0d last=%b rin=%h rsh=%0d expected all zero",
                     bus.out_valid, bus.busy, bus.out_data, bus.out_shift, bus.out_last,
                     bus.rot_in, bus.rot_shift);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_cmd_ready got %b expected 1", bus.cmd_ready);
        end
    endtask

    task automatic test_single;
        bus.out_ready = 1'b1;
        bus.cmd_data  = 8'h81;
        bus.cmd_amt   = 3'd1;
        bus.cmd_mode  = 2'b00;
        bus.cmd_count = 3'd5;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tests++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_run got busy=%b ready=%b v=%b expected 1 0 0",
                     bus.busy, bus.cmd_ready, bus.out_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h03 || bus.out_shift !== 3'd1 ||
            bus.out_last !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_beat got v=%b d=%h sh=%0d last=%b ready=%b expected 1 03 1 1 1",
                     bus.out_valid, bus.out_data, bus.out_shift, bus.out_last, bus.cmd_ready);
        end
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL single_after got v=%b busy=%b expected 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_sweep;
        int cyc;
        do_cmd(8'h01, 3'd6, 2'b01, 3'd0, 0, -1, 0, cyc);
        tests++;
        if (cyc !== 8) begin
            fails++;
            $display("FAIL sweep_no_bubble got %0d cycles expected 8", cyc);
        end
    endtask

    task automatic test_accum;
        int cyc;
        do_cmd(8'h01, 3'd3, 2'b10, 3'd2, 0, -1, 0, cyc);
        tests++;
        if (cyc !== 3) begin
            fails++;
            $display("FAIL accum_cycles got %0d expected 3", cyc);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        do_cmd(8'h5A, 3'd2, 2'b01, 3'd0, 0, 1, 5, cyc);
        tests++;
        if (cyc !== 13) begin
            fails++;
            $display("FAIL backpressure_cycles got %0d expected 13", cyc);
        end
    endtask

    task automatic test_reset_abort;
        int beats;
        int cyc;
        bus.out_ready = 1'b1;
        bus.cmd_data  = 8'h01;
        bus.cmd_amt   = 3'd0;
        bus.cmd_mode  = 2'b01;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        beats = 0;
        for (int i = 0; i < 20 && beats < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) beats++;
        end
        tests++;
        if (beats != 3) begin
            fails++;
            $display("FAIL abort_prefix got %0d beats expected 3", beats);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rot_in !== 8'h00) begin
            fails++;
            $display("FAIL abort_async got v=%b busy=%b rin=%h expected 0 0 00",
                     bus.out_valid, bus.busy, bus.rot_in);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.cmd_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_release got ready=%b v=%b expected 1 0", bus.cmd_ready, bus.out_valid);
        end
        do_cmd(8'h80, 3'd1, 2'b00, 3'd0, 0, -1, 0, cyc);
    endtask

    task automatic test_mode11_hold;
        bus.out_ready = 1'b1;
        bus.cmd_data  = 8'hF0;
        bus.cmd_amt   = 3'd4;
        bus.cmd_mode  = 2'b11;
        bus.cmd_count = 3'd6;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL m11_run got busy=%b ready=%b expected 1 0", bus.busy, bus.cmd_ready);
        end
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h0F || bus.out_shift !== 3'd4 ||
            bus.out_last !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL m11_beat got v=%b d=%h sh=%0d last=%b ready=%b expected 1 0f 4 1 1",
                     bus.out_valid, bus.out_data, bus.out_shift, bus.out_last, bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        tests++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL m11_reaccept got busy=%b v=%b expected 1 0", bus.busy, bus.out_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h0F || bus.out_last !== 1'b1) begin
            fails++;
            $display("FAIL m11_beat2 got v=%b d=%h last=%b expected 1 0f 1",
                     bus.out_valid, bus.out_data, bus.out_last);
        end
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL m11_end got v=%b busy=%b expected 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_random;
        int cyc;
        for (int n = 0; n < 40; n++) begin
            do_cmd(8'($urandom), 3'($urandom), 2'($urandom), 3'($urandom), 1, -1, 0, cyc);
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.cmd_amt   = 3'd0;
        bus.cmd_mode  = 2'b00;
        bus.cmd_count = 3'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_sweep();
        test_accum();
        test_backpressure();
        test_reset_abort();
        test_mode11_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
